glb_iact_responder: RTL
=======================

# glb_iact_responder

Global-buffer-side responder for the iact read interface used by the iact routers. It is loaded with a block of input activations from an external stream. Once loaded, it answers the router's read requests (address plus request strobe) with one data word and an enable pulse. That enable/data pair drives a router source port, so the router's priority mux and spad-load pulse logic see one enable per requested word.

## Interface
Parameters:
- DATA_BITWIDTH, 16, activation word width (signed)
- ADDR_BITWIDTH_GLB, 10, GLB address width; memory depth 2^ADDR_BITWIDTH_GLB
- LOAD_BASE, 100, first address written by a fill (matches router A_READ_ADDR default)
- FILL_WORDS, 25, words per fill (act_size*act_size for act_size=5)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fill_start  in  1  pulse: begin a fill (honoured only in IDLE)
- fill_data  in  DATA_BITWIDTH  fill word
- fill_valid  in  1  fill word strobe
- clear  in  1  pulse: return READY to IDLE
- read_addr  in  ADDR_BITWIDTH_GLB  router read address
- read_req  in  1  router read strobe
- data_o  out  DATA_BITWIDTH  response word (signed)
- enable_o  out  1  response valid, one cycle per accepted request
- rd_err  out  1  pulse: request rejected (not READY)
- fill_done  out  1  pulse: last fill word written
- busy  out  1  high in FILL
- ready  out  1  high in READY
- words_loaded  out  ADDR_BITWIDTH_GLB  fill words written since fill_start

## Operation
- FSM states are IDLE, FILL and READY. Reset state is IDLE.
- IDLE → FILL on fill_start. On entry, the write pointer is set to LOAD_BASE and words_loaded is cleared to 0.
- FILL behaviour:
  - Each fill_valid writes fill_data to the write pointer, then increments the pointer and words_loaded.
  - The pointer wraps modulo 2^ADDR_BITWIDTH_GLB.
  - On the write where words_loaded reaches FILL_WORDS: fill_done pulses and the FSM moves to READY.
- READY → IDLE on clear. words_loaded holds its value.
- Ignored inputs:
  - fill_start outside IDLE.
  - fill_valid outside FILL.
  - clear outside READY.
- read_req in READY is accepted: the memory is read at read_addr.
- read_req in IDLE or FILL is rejected: no memory read, enable_o stays low, rd_err pulses.
- A read and a write to the same address in the same cycle returns the old data. This only arises via external misuse, because reads are rejected in FILL.
- While enable_o is low, data_o is 0. data_o never leaks stale memory output.
- Memory contents survive reset and clear. Contents are undefined after power-up until written.

## Timing
- Output reset values: data_o=0, enable_o=0, rd_err=0, fill_done=0, busy=0, ready=0, words_loaded=0.
- Read latency is 1 cycle: a read_req accepted in cycle N gives enable_o=1 with data_o=mem[read_addr] in cycle N+1.
- Back-to-back reads: one accepted request per cycle gives a continuous enable_o high, one word per cycle.
- rd_err is registered and asserts in cycle N+1 for a rejected request in cycle N.
- Fill write is 1 cycle. fill_done asserts in the cycle after the last accepted fill_valid, together with ready=1.
- A read_req in the same cycle as the final fill write is rejected, because the FSM is still in FILL.
- clear and read_req in the same cycle: the read is accepted, its response still appears the next cycle, and the FSM goes to IDLE.
- fill_start with fill_valid in the same cycle: only the state change happens; the word is not written.
- reset mid-FILL: the FSM returns to IDLE and the pointer and counter clear. A pending read response is cancelled, so enable_o=0 in the following cycle.
- The busy and ready flags are registered decodes of the state.

## Structure
- Shared package glb_pkg holds:
  - the state enum (IDLE=0, FILL=1, READY=2);
  - the default widths DATA_BITWIDTH and ADDR_BITWIDTH_GLB;
  - LOAD_BASE.
- One sub-module, glb_sram_1r1w: synchronous 1-read/1-write array with registered read, read-before-write on collision, no reset on contents.
- Top level contains the FSM, write pointer, words_loaded counter, and response/rd_err registers.

## Test plan
- Fill and read: fill_start, then 25 fill_valid with data 1..25 → fill_done pulses once in the cycle after the 25th word, ready=1. read_req at addresses 100..124 on consecutive cycles → enable_o high for 25 cycles with data_o=1..25, each one cycle after its request.
- Early read: read_req at address 100 during FILL → rd_err=1 the next cycle, enable_o=0, data_o=0.
- Wrap: with LOAD_BASE=1020 and ADDR_BITWIDTH_GLB=10, fill 8 words (-1..-8) → reads at 1020..1023 then 0..3 return -1..-8, sign intact.
- Gapped fill: fill_valid toggling every other cycle → words_loaded steps 0→25 exactly, no duplicate writes. fill_start issued mid-FILL is ignored.
- Reset mid-operation: reset asserted at word 10 of a fill → all outputs at reset values the next cycle. A fresh fill then completes normally. Reset during an accepted read → no enable_o pulse.
- Clear collision: clear together with read_req at address 105 → enable_o=1 with the data at 105 the next cycle, ready=0 thereafter, and later reads give rd_err.

Source files
------------

// File: rtl/glb_pkg.sv
// Shared types and default sizes for the global-buffer iact responder.
package glb_pkg;

    localparam int DATA_BITWIDTH     = 16;
    localparam int ADDR_BITWIDTH_GLB = 10;
    localparam int LOAD_BASE         = 100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } glb_state_e;

endpackage

// File: rtl/glb_sram_1r1w.sv
// Simple dual-port array: one synchronous write port and one registered read port.
// A read and a write to the same address in one cycle returns the old contents.
module glb_sram_1r1w #(
    parameter int DATA_BITWIDTH     = glb_pkg::DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH_GLB = glb_pkg::ADDR_BITWIDTH_GLB
) (
    input  logic                                clk,
    input  logic                                wr_en,
    input  logic        [ADDR_BITWIDTH_GLB-1:0] wr_addr,
    input  logic signed [DATA_BITWIDTH-1:0]     wr_data,
    input  logic                                rd_en,
    input  logic        [ADDR_BITWIDTH_GLB-1:0] rd_addr,
    output logic signed [DATA_BITWIDTH-1:0]     rd_data
);

    localparam int DEPTH = 2 ** ADDR_BITWIDTH_GLB;

    logic signed [DATA_BITWIDTH-1:0] mem [0:DEPTH-1];

    // Array write and registered read; non-blocking update gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/glb_iact_responder.sv
// GLB-side iact responder: loads a block of activations from a stream, then
// answers router read requests with one data word plus one enable pulse each.
module glb_iact_responder #(
    parameter int DATA_BITWIDTH     = glb_pkg::DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH_GLB = glb_pkg::ADDR_BITWIDTH_GLB,
    parameter int LOAD_BASE         = glb_pkg::LOAD_BASE,
    parameter int FILL_WORDS        = 25
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                fill_start,
    input  logic signed [DATA_BITWIDTH-1:0]     fill_data,
    input  logic                                fill_valid,
    input  logic                                clear,
    input  logic        [ADDR_BITWIDTH_GLB-1:0] read_addr,
    input  logic                                read_req,
    output logic signed [DATA_BITWIDTH-1:0]     data_o,
    output logic                                enable_o,
    output logic                                rd_err,
    output logic                                fill_done,
    output logic                                busy,
    output logic                                ready,
    output logic        [ADDR_BITWIDTH_GLB-1:0] words_loaded
);

    import glb_pkg::*;

    localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE_ADDR  = ADDR_BITWIDTH_GLB'(LOAD_BASE);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] FILL_COUNT = ADDR_BITWIDTH_GLB'(FILL_WORDS);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] ONE        = ADDR_BITWIDTH_GLB'(1);

    glb_state_e                      state;
    glb_state_e                      state_next;
    logic [ADDR_BITWIDTH_GLB-1:0]    wr_ptr;
    logic [ADDR_BITWIDTH_GLB-1:0]    words_next;
    logic                            wr_en;
    logic                            rd_accept;
    logic                            rd_reject;
    logic                            last_word;
    logic                            rsp_valid;
    logic signed [DATA_BITWIDTH-1:0] sram_rd_data;

    assign words_next = words_loaded + ONE;

    // Next-state decode plus the per-cycle write/read qualification strobes.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        rd_accept  = 1'b0;
        rd_reject  = 1'b0;
        last_word  = 1'b0;
        case (state)
            IDLE: begin
                rd_reject = read_req;
                if (fill_start) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                rd_reject = read_req;
                if (fill_valid) begin
                    wr_en = 1'b1;
                    if (words_next == FILL_COUNT) begin
                        last_word  = 1'b1;
                        state_next = READY;
                    end
                end
            end
            READY: begin
                rd_accept = read_req;
                if (clear) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write pointer and fill counter; both restart when a fill begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= BASE_ADDR;
            words_loaded <= '0;
        end else if (state == IDLE && fill_start) begin
            wr_ptr       <= BASE_ADDR;
            words_loaded <= '0;
        end else if (wr_en) begin
            wr_ptr       <= wr_ptr + ONE;
            words_loaded <= words_next;
        end
    end

    // Registered response strobes and status flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rd_err    <= 1'b0;
            fill_done <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
        end else begin
            rsp_valid <= rd_accept;
            rd_err    <= rd_reject;
            fill_done <= last_word;
            busy      <= (state_next == FILL);
            ready     <= (state_next == READY);
        end
    end

    glb_sram_1r1w #(
        .DATA_BITWIDTH    (DATA_BITWIDTH),
        .ADDR_BITWIDTH_GLB(ADDR_BITWIDTH_GLB)
    ) u_sram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(fill_data),
        .rd_en  (rd_accept),
        .rd_addr(read_addr),
        .rd_data(sram_rd_data)
    );

    // The array output is only exposed alongside its enable so no stale word leaks.
    assign enable_o = rsp_valid;
    assign data_o   = rsp_valid ? sram_rd_data : '0;

endmodule
